// File: rtl/bc_pkg.sv
// Shared codes for the basic-computer control unit:
// bus source select, ALU op codes, ctrl strobe bit indices.
package bc_pkg;

  typedef enum logic [2:0] {
    BUS_NONE = 3'b000,
    BUS_PC   = 3'b001,
    BUS_DR   = 3'b010,
    BUS_AC   = 3'b011,
    BUS_IR   = 3'b100,
    BUS_TR   = 3'b101,
    BUS_MEM  = 3'b110,
    BUS_AR   = 3'b111
  } bus_sel_e;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_ADD  = 3'b001,
    ALU_PDR  = 3'b010,
    ALU_CMA  = 3'b011,
    ALU_CIL  = 3'b100,
    ALU_CIR  = 3'b101,
    ALU_HOLD = 3'b111
  } alu_op_e;

  localparam int CTRL_W = 16;

  localparam int LD_AR  = 0;
  localparam int INR_AR = 1;
  localparam int CLR_AR = 2;
  localparam int LD_PC  = 3;
  localparam int INR_PC = 4;
  localparam int CLR_PC = 5;
  localparam int LD_DR  = 6;
  localparam int INR_DR = 7;
  localparam int LD_AC  = 8;
  localparam int INR_AC = 9;
  localparam int CLR_AC = 10;
  localparam int LD_IR  = 11;
  localparam int LD_TR  = 12;
  localparam int MEM_WR = 13;
  localparam int CLR_E  = 14;
  localparam int CMP_E  = 15;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_REG = 3'd7;

  // One-hot of the highest set bit; register-reference
  // instructions honour only their top operation bit.
  function automatic logic [11:0] msb_onehot(
    input logic [11:0] v
  );
    logic [11:0] r;
    r = '0;
    for (int b = 0; b < 12; b++)
      if (v[b]) r = 12'(1) << b;
    return r;
  endfunction

endpackage

// File: rtl/bc_seq_cnt.sv
// 4-bit sequence counter. clr beats inr; hold freezes.
// Ports: clk, rst (async high), clr, inr, hold -> sc.
module bc_seq_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inr,
  input  logic       hold,
  output logic [3:0] sc
);

  logic [3:0] sc_q, sc_d;

  always_comb begin
    sc_d = sc_q;
    if (clr)
      sc_d = '0;
    else if (inr && !hold)
      sc_d = sc_q + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sc_q <= '0;
    else     sc_q <= sc_d;
  end

  assign sc = sc_q;

endmodule

// File: rtl/bc_ctrl_fsm.sv
// Basic-computer hardwired control: decodes sc/IR/flags
// into bus select, register strobes and ALU op.
// Ports: clk, rst, IR, N, Z, E, DR_Z, int_req, fgi in;
// BUS_SEL, ctrl, alu_op, sc, halt, ien out.
module bc_ctrl_fsm
  import bc_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter bit INT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  IR,
  input  logic              N,
  input  logic              Z,
  input  logic              E,
  input  logic              DR_Z,
  input  logic              int_req,
  input  logic              fgi,
  output logic [2:0]        BUS_SEL,
  output logic [CTRL_W-1:0] ctrl,
  output logic [2:0]        alu_op,
  output logic [3:0]        sc,
  output logic              halt,
  output logic              ien
);

  logic [2:0]        opc;
  logic [11:0]       rr;
  logic              i_q, i_d;
  logic              r_q, r_d;
  logic              ien_q, ien_d;
  logic              halt_q, halt_d;
  logic              sc_clr;
  bus_sel_e          bus;
  alu_op_e           alu;
  logic [CTRL_W-1:0] ctl;

  assign opc = IR[WIDTH-2:WIDTH-4];
  assign rr  = msb_onehot(IR[11:0]);

  bc_seq_cnt u_seq (
    .clk  (clk),
    .rst  (rst),
    .clr  (sc_clr),
    .inr  (1'b1),
    .hold (halt_q),
    .sc   (sc)
  );

  always_comb begin
    bus    = BUS_NONE;
    alu    = ALU_HOLD;
    ctl    = '0;
    sc_clr = 1'b0;
    i_d    = i_q;
    r_d    = r_q;
    ien_d  = ien_q;
    halt_d = halt_q;

    // Interrupt request is only latched outside T0-T2.
    if (INT_EN && sc > 4'd2 && ien_q && int_req)
      r_d = 1'b1;

    if (!rst && !halt_q) begin
      if (sc <= 4'd2) begin
        if (r_q) begin
          case (sc)
            4'd0: begin
              bus         = BUS_PC;
              ctl[CLR_AR] = 1'b1;
              ctl[LD_TR]  = 1'b1;
            end
            4'd1: begin
              bus         = BUS_TR;
              ctl[MEM_WR] = 1'b1;
              ctl[CLR_PC] = 1'b1;
            end
            default: begin
              ctl[INR_PC] = 1'b1;
              ien_d       = 1'b0;
              r_d         = 1'b0;
              sc_clr      = 1'b1;
            end
          endcase
        end else begin
          case (sc)
            4'd0: begin
              bus        = BUS_PC;
              ctl[LD_AR] = 1'b1;
            end
            4'd1: begin
              bus         = BUS_MEM;
              ctl[LD_IR]  = 1'b1;
              ctl[INR_PC] = 1'b1;
            end
            default: begin
              bus        = BUS_IR;
              ctl[LD_AR] = 1'b1;
              i_d        = IR[WIDTH-1];
            end
          endcase
        end
      end else begin
        case (sc)
          4'd3: begin
            if (opc == OP_REG) begin
              sc_clr = 1'b1;
              if (!i_q) begin
                unique case (1'b1)
                  rr[11]: ctl[CLR_AC] = 1'b1;
                  rr[10]: ctl[CLR_E]  = 1'b1;
                  rr[9]: begin
                    ctl[LD_AC] = 1'b1;
                    alu        = ALU_CMA;
                  end
                  rr[8]: ctl[CMP_E] = 1'b1;
                  rr[7]: begin
                    ctl[LD_AC] = 1'b1;
                    alu        = ALU_CIR;
                  end
                  rr[6]: begin
                    ctl[LD_AC] = 1'b1;
                    alu        = ALU_CIL;
                  end
                  rr[5]: ctl[INR_AC] = 1'b1;
                  rr[4]: ctl[INR_PC] = !N;
                  rr[3]: ctl[INR_PC] = N;
                  rr[2]: ctl[INR_PC] = Z;
                  rr[1]: ctl[INR_PC] = !E;
                  rr[0]: halt_d = 1'b1;
                  default: ;
                endcase
              end else if (INT_EN) begin
                ctl[INR_PC] = IR[9] && fgi;
                if (IR[7]) ien_d = 1'b1;
                if (IR[6]) ien_d = 1'b0;
              end
            end else if (i_q) begin
              bus        = BUS_MEM;
              ctl[LD_AR] = 1'b1;
            end
          end
          4'd4: begin
            case (opc)
              OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                bus        = BUS_MEM;
                ctl[LD_DR] = 1'b1;
              end
              OP_STA: begin
                bus         = BUS_AC;
                ctl[MEM_WR] = 1'b1;
                sc_clr      = 1'b1;
              end
              OP_BUN: begin
                bus        = BUS_AR;
                ctl[LD_PC] = 1'b1;
                sc_clr     = 1'b1;
              end
              OP_BSA: begin
                bus         = BUS_PC;
                ctl[MEM_WR] = 1'b1;
                ctl[INR_AR] = 1'b1;
              end
              default: ;
            endcase
          end
          4'd5: begin
            case (opc)
              OP_AND, OP_ADD, OP_LDA: begin
                ctl[LD_AC] = 1'b1;
                alu        = alu_op_e'(opc);
                sc_clr     = 1'b1;
              end
              OP_BSA: begin
                bus        = BUS_AR;
                ctl[LD_PC] = 1'b1;
                sc_clr     = 1'b1;
              end
              OP_ISZ: ctl[INR_DR] = 1'b1;
              default: ;
            endcase
          end
          4'd6: begin
            if (opc == OP_ISZ) begin
              bus         = BUS_DR;
              ctl[MEM_WR] = 1'b1;
              ctl[INR_PC] = DR_Z;
              sc_clr      = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q    <= 1'b0;
      r_q    <= 1'b0;
      ien_q  <= 1'b0;
      halt_q <= 1'b0;
    end else begin
      i_q    <= i_d;
      r_q    <= r_d;
      ien_q  <= ien_d;
      halt_q <= halt_d;
    end
  end

  assign BUS_SEL = bus;
  assign ctrl    = ctl;
  assign alu_op  = alu;
  assign halt    = halt_q;
  assign ien     = ien_q;

endmodule

// File: tb/tb_bc_ctrl_fsm.sv
// Self-checking bench for bc_ctrl_fsm: per-instruction
// micro-op tables compared cycle by cycle with the DUT.
module tb_bc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] IR = '0;
  logic        N = 0, Z = 0, E = 0, DR_Z = 0;
  logic        int_req = 0, fgi = 0;
  logic [2:0]  BUS_SEL;
  logic [15:0] ctrl;
  logic [2:0]  alu_op;
  logic [3:0]  sc;
  logic        halt, ien;

  always #5 clk = ~clk;

  bc_ctrl_fsm #(.WIDTH(16), .INT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .IR(IR),
    .N(N), .Z(Z), .E(E), .DR_Z(DR_Z),
    .int_req(int_req), .fgi(fgi),
    .BUS_SEL(BUS_SEL), .ctrl(ctrl), .alu_op(alu_op),
    .sc(sc), .halt(halt), .ien(ien)
  );

  localparam logic [2:0] B_NONE = 0, B_PC = 1, B_DR = 2;
  localparam logic [2:0] B_AC = 3, B_IR = 4, B_TR = 5;
  localparam logic [2:0] B_MEM = 6, B_AR = 7;
  localparam logic [2:0] A_HOLD = 7;

  localparam logic [15:0] C_LD_AR  = 16'h0001;
  localparam logic [15:0] C_INR_AR = 16'h0002;
  localparam logic [15:0] C_CLR_AR = 16'h0004;
  localparam logic [15:0] C_LD_PC  = 16'h0008;
  localparam logic [15:0] C_INR_PC = 16'h0010;
  localparam logic [15:0] C_CLR_PC = 16'h0020;
  localparam logic [15:0] C_LD_DR  = 16'h0040;
  localparam logic [15:0] C_INR_DR = 16'h0080;
  localparam logic [15:0] C_LD_AC  = 16'h0100;
  localparam logic [15:0] C_INR_AC = 16'h0200;
  localparam logic [15:0] C_CLR_AC = 16'h0400;
  localparam logic [15:0] C_LD_IR  = 16'h0800;
  localparam logic [15:0] C_LD_TR  = 16'h1000;
  localparam logic [15:0] C_MEM_WR = 16'h2000;
  localparam logic [15:0] C_CLR_E  = 16'h4000;
  localparam logic [15:0] C_CMP_E  = 16'h8000;

  typedef struct packed {
    logic [2:0]  bus;
    logic [15:0] ctl;
    logic [2:0]  alu;
  } uop_t;

  uop_t prog[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   ien_m = 0, halt_m = 0, r_m = 0;
  bit   e_ion, e_iof, e_hlt, e_intr;
  int   irq_mode = 0;

  function automatic uop_t u(input logic [2:0] b,
                             input logic [15:0] c,
                             input logic [2:0] a = 3'd7);
    return '{bus: b, ctl: c, alu: a};
  endfunction

  task automatic build_intr();
    prog.delete();
    {e_ion, e_iof, e_hlt} = 3'b000;
    e_intr = 1;
    prog.push_back(u(B_PC, C_CLR_AR | C_LD_TR));
    prog.push_back(u(B_TR, C_MEM_WR | C_CLR_PC));
    prog.push_back(u(B_NONE, C_INR_PC));
  endtask

  task automatic build_instr();
    logic [2:0]  opc;
    logic [15:0] c;
    logic [2:0]  a;
    int          h;
    opc = IR[14:12];
    prog.delete();
    {e_ion, e_iof, e_hlt, e_intr} = 4'b0000;
    prog.push_back(u(B_PC, C_LD_AR));
    prog.push_back(u(B_MEM, C_LD_IR | C_INR_PC));
    prog.push_back(u(B_IR, C_LD_AR));
    if (opc == 3'd7 && !IR[15]) begin
      h = -1;
      for (int b = 0; b < 12; b++)
        if (IR[b]) h = b;
      c = '0;
      a = A_HOLD;
      case (h)
        11: c = C_CLR_AC;
        10: c = C_CLR_E;
        9: begin c = C_LD_AC; a = 3'd3; end
        8: c = C_CMP_E;
        7: begin c = C_LD_AC; a = 3'd5; end
        6: begin c = C_LD_AC; a = 3'd4; end
        5: c = C_INR_AC;
        4: c = N ? 16'h0 : C_INR_PC;
        3: c = N ? C_INR_PC : 16'h0;
        2: c = Z ? C_INR_PC : 16'h0;
        1: c = E ? 16'h0 : C_INR_PC;
        0: e_hlt = 1;
        default: ;
      endcase
      prog.push_back(u(B_NONE, c, a));
    end else if (opc == 3'd7) begin
      c = (IR[9] && fgi) ? C_INR_PC : 16'h0;
      e_ion = IR[7];
      e_iof = IR[6];
      prog.push_back(u(B_NONE, c));
    end else begin
      if (IR[15]) prog.push_back(u(B_MEM, C_LD_AR));
      else        prog.push_back(u(B_NONE, 16'h0));
      case (opc)
        3'd0, 3'd1, 3'd2: begin
          prog.push_back(u(B_MEM, C_LD_DR));
          prog.push_back(u(B_NONE, C_LD_AC, opc));
        end
        3'd3: prog.push_back(u(B_AC, C_MEM_WR));
        3'd4: prog.push_back(u(B_AR, C_LD_PC));
        3'd5: begin
          prog.push_back(u(B_PC, C_MEM_WR | C_INR_AR));
          prog.push_back(u(B_AR, C_LD_PC));
        end
        default: begin
          prog.push_back(u(B_MEM, C_LD_DR));
          prog.push_back(u(B_NONE, C_INR_DR));
          prog.push_back(u(B_DR, C_MEM_WR |
                           (DR_Z ? C_INR_PC : 16'h0)));
        end
      endcase
    end
  endtask

  // Entered just after a rising edge, in the routine's
  // first cycle; leaves just after the edge closing it.
  task automatic run_prog(input int limit);
    for (int k = 0; k < prog.size() && k < limit; k++) begin
      case (irq_mode)
        0:       int_req = 0;
        1:       int_req = ($urandom_range(3) == 0);
        default: int_req = (k == 3);
      endcase
      @(negedge clk);
      n_chk++;
      if (BUS_SEL !== prog[k].bus || ctrl !== prog[k].ctl ||
          alu_op !== prog[k].alu || sc !== k[3:0]) begin
        n_fail++;
        $display("FAIL step%0d ir=%h: bus=%0d ctrl=%h alu=%0d sc=%0d want bus=%0d ctrl=%h alu=%0d sc=%0d",
                 k, IR, BUS_SEL, ctrl, alu_op, sc,
                 prog[k].bus, prog[k].ctl, prog[k].alu, k);
      end
      n_chk++;
      if (ien !== ien_m || halt !== halt_m) begin
        n_fail++;
        $display("FAIL flags step%0d ir=%h: ien=%b halt=%b want ien=%b halt=%b",
                 k, IR, ien, halt, ien_m, halt_m);
      end
      @(posedge clk);
      if (k >= 3 && ien_m && int_req) r_m = 1;
      if (k == prog.size() - 1) begin
        if (e_intr) begin r_m = 0; ien_m = 0; end
        if (e_iof)      ien_m = 0;
        else if (e_ion) ien_m = 1;
        if (e_hlt) halt_m = 1;
      end
      #1;
    end
  endtask

  task automatic exec_instr(input logic [15:0] ir,
                            input logic [4:0] fl);
    IR = ir;
    {N, Z, E, DR_Z, fgi} = fl;
    build_instr();
    run_prog(99);
  endtask

  task automatic model_reset();
    ien_m = 0; halt_m = 0; r_m = 0;
  endtask

  task automatic test_reset();
    #2;
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (ctrl !== 16'h0 || BUS_SEL !== B_NONE ||
          alu_op !== A_HOLD || sc !== 4'd0 ||
          halt !== 1'b0 || ien !== 1'b0) begin
        n_fail++;
        $display("FAIL reset%0d: ctrl=%h bus=%0d alu=%0d sc=%0d halt=%b ien=%b",
                 i, ctrl, BUS_SEL, alu_op, sc, halt, ien);
      end
      @(posedge clk);
      #1;
    end
    rst = 0;
    model_reset();
  endtask

  task automatic test_directed();
    exec_instr(16'h7800, 5'b0);
    exec_instr(16'h8005, 5'b0);
    exec_instr(16'h6010, 5'b00010);
    exec_instr(16'h6010, 5'b00000);
    exec_instr(16'h7010, 5'b00000);
    exec_instr(16'h7010, 5'b10000);
    exec_instr(16'hF200, 5'b00001);
  endtask

  task automatic test_interrupt();
    irq_mode = 0;
    exec_instr(16'hF080, 5'b0);
    irq_mode = 2;
    exec_instr(16'h7800, 5'b0);
    irq_mode = 0;
    build_intr();
    run_prog(99);
    exec_instr(16'h7800, 5'b0);
  endtask

  task automatic test_reset_mid();
    IR = 16'h1005;
    {N, Z, E, DR_Z, fgi} = 5'b0;
    build_instr();
    run_prog(5);
    n_chk++;
    if (ctrl !== C_LD_AC || alu_op !== 3'd1 || sc !== 4'd5) begin
      n_fail++;
      $display("FAIL add_t5: ctrl=%h alu=%0d sc=%0d want ctrl=%h alu=1 sc=5",
               ctrl, alu_op, sc, C_LD_AC);
    end
    #2 rst = 1;
    #1;
    n_chk++;
    if (ctrl !== 16'h0 || sc !== 4'd0 ||
        BUS_SEL !== B_NONE || alu_op !== A_HOLD) begin
      n_fail++;
      $display("FAIL async_rst: ctrl=%h sc=%0d bus=%0d alu=%0d want 0 0 0 7",
               ctrl, sc, BUS_SEL, alu_op);
    end
    @(posedge clk);
    #1 rst = 0;
    model_reset();
    exec_instr(16'h1005, 5'b0);
  endtask

  task automatic test_random();
    logic [15:0] r;
    irq_mode = 1;
    for (int n = 0; n < 200; n++) begin
      if (r_m) begin
        build_intr();
        run_prog(99);
      end else begin
        r = 16'($urandom);
        if (r[14:12] == 3'd7 && $urandom_range(1) == 1)
          r[11:0] = 12'(1) << $urandom_range(11);
        if (r[15:12] == 4'h7 && r[11:0] == 12'h001)
          r[11:0] = 12'h800;
        exec_instr(r, 5'($urandom));
      end
    end
    irq_mode = 0;
  endtask

  task automatic test_halt();
    exec_instr(16'h7001, 5'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_chk++;
      if (halt !== 1'b1 || sc !== 4'd0 || ctrl !== 16'h0 ||
          BUS_SEL !== B_NONE || alu_op !== A_HOLD) begin
        n_fail++;
        $display("FAIL halt%0d: halt=%b sc=%0d ctrl=%h bus=%0d alu=%0d",
                 i, halt, sc, ctrl, BUS_SEL, alu_op);
      end
    end
    @(posedge clk);
    #1 rst = 1;
    #1;
    n_chk++;
    if (halt !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_clear: halt=%b want 0", halt);
    end
    @(posedge clk);
    #1 rst = 0;
    model_reset();
    exec_instr(16'h7800, 5'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_interrupt();
    test_reset_mid();
    test_random();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
